// File: rtl/psram_pkg.sv
// Shared definitions for the async PSRAM controller.
// - state_e     : controller FSM states
// - DEF_*       : default geometry and timing
// - cnt_width() : width of the phase timer for a given access/recovery length
package psram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam int DEF_ADDR_W     = 23;
  localparam int DEF_DATA_W     = 16;
  // 4 x 20 ns at 50 MHz covers the 70 ns tAA/tWP of the part
  localparam int DEF_ACC_CYCLES = 4;
  localparam int DEF_REC_CYCLES = 1;

  // Enough bits to hold the longer of the two programmable phases.
  function automatic int cnt_width(input int acc, input int rec);
    int m;
    m = (acc > rec) ? acc : rec;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/psram_timer.sv
// Loadable phase down-counter.
// - load/load_val : (re)start the count; takes priority over counting
// - done          : high while the count is 1, i.e. in the last clock of a phase
// The counter parks at zero when not reloaded.
module psram_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/psram_async_ctrl.sv
// Async-mode controller for the cellular PSRAM.
// One read or write per req/ready handshake; every pin is driven from a flop.
// Sequence: IDLE -> SETUP (1 clk) -> ACCESS (ACC_CYCLES) -> RECOVER (REC_CYCLES).
// Ports:
//   clock, reset_n                  : clock, async active-low reset
//   req, we, addr_in, wdata, be     : request, sampled when req & ready
//   ready, ack, rdata               : idle flag, completion pulse, last read data
//   mem_addr, mem_ce_n, mem_oe_n,
//   mem_we_n, mem_adv_n, mem_be_n   : RAM control pins (ADV tied low, async mode)
//   mem_wait                        : RAM WAIT, unused in async mode
//   mem_data                        : RAM data bus, driven only around writes
module psram_async_ctrl
  import psram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BE_W       = DATA_W / 8,
  parameter int ACC_CYCLES = DEF_ACC_CYCLES,
  parameter int REC_CYCLES = DEF_REC_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_adv_n,
  output logic [BE_W-1:0]   mem_be_n,
  input  logic              mem_wait,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int CNT_W = cnt_width(ACC_CYCLES, REC_CYCLES);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                drv_q, drv_d;
  logic                ack_q, ack_d;
  logic                ready_q, ready_d;

  logic                accept;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_done;

  logic                unused_wait;
  assign unused_wait = mem_wait;

  psram_timer #(.W(CNT_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_n_d   = be_n_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = (state_q == ST_IDLE) && req;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          we_d    = we;
          addr_d  = addr_in;
          wdata_d = wdata;
          be_n_d  = ~be;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(ACC_CYCLES);
      end
      ST_ACCESS: begin
        if (tmr_done) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(REC_CYCLES);
          be_n_d   = '1;
          // Last ACCESS clock: data has been valid for the full tAA window.
          if (!we_q) rdata_d = mem_data;
        end
      end
      ST_RECOVER: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin values follow the state being entered so they are registered.
    ce_n_d  = !((state_d == ST_SETUP) || (state_d == ST_ACCESS));
    oe_n_d  = !((state_d == ST_ACCESS) && !we_d);
    we_n_d  = !((state_d == ST_ACCESS) &&  we_d);
    // Write drive spans SETUP, ACCESS and one RECOVER clock for data hold.
    drv_d   = accept ? we : (we_q && ((state_q == ST_SETUP) || (state_q == ST_ACCESS)));
    ack_d   = (state_q == ST_ACCESS) && (state_d == ST_RECOVER);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drv_q   <= drv_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_adv_n = 1'b0;
  assign mem_be_n  = be_n_q;
  assign mem_data  = drv_q ? wdata_q : 'z;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Bench for psram_async_ctrl: dut0 with default timing (ACC=4, REC=1) and
// dut1 with ACC=1, REC=3, each on its own behavioural RAM. Expected read data
// comes from an address-keyed reference memory updated per request.
module tb_psram_async_ctrl;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int BW = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset_n;
  logic [1:0]            req, we;
  logic [1:0][AW-1:0]    addr_in;
  logic [1:0][DW-1:0]    wdata;
  logic [1:0][BW-1:0]    be;
  wire  [1:0]            ready, ack, ce_n, oe_n, we_n, adv_n;
  wire  [1:0][DW-1:0]    rdata;
  wire  [1:0][AW-1:0]    mem_addr;
  wire  [1:0][BW-1:0]    be_n;
  wire  [DW-1:0]         bus0, bus1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_acc [2];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] refm [bit [AW:0]];

  always @(posedge clock) cyc <= cyc + 1;

  psram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(4), .REC_CYCLES(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req[0]), .we(we[0]), .addr_in(addr_in[0]),
    .wdata(wdata[0]), .be(be[0]), .ready(ready[0]), .ack(ack[0]), .rdata(rdata[0]),
    .mem_addr(mem_addr[0]), .mem_ce_n(ce_n[0]), .mem_oe_n(oe_n[0]), .mem_we_n(we_n[0]),
    .mem_adv_n(adv_n[0]), .mem_be_n(be_n[0]), .mem_wait(1'b0), .mem_data(bus0));

  psram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(1), .REC_CYCLES(3)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req[1]), .we(we[1]), .addr_in(addr_in[1]),
    .wdata(wdata[1]), .be(be[1]), .ready(ready[1]), .ack(ack[1]), .rdata(rdata[1]),
    .mem_addr(mem_addr[1]), .mem_ce_n(ce_n[1]), .mem_oe_n(oe_n[1]), .mem_we_n(we_n[1]),
    .mem_adv_n(adv_n[1]), .mem_be_n(be_n[1]), .mem_wait(1'b0), .mem_data(bus1));

  // Behavioural RAM per DUT: 256 words indexed by the low address byte
  // (bench addresses are chosen with distinct low bytes). Writes honour lanes;
  // reads drive the whole word while CE and OE are low.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [DW-1:0] mem [256];
    logic [DW-1:0] dout;
    wire  [DW-1:0] busv = (g == 0) ? bus0 : bus1;
    initial for (int k = 0; k < 256; k++) mem[k] <= '0;
    always @(negedge clock) begin
      if (!ce_n[g] && !we_n[g])
        for (int i = 0; i < BW; i++)
          if (!be_n[g][i]) mem[mem_addr[g][7:0]][8*i +: 8] <= busv[8*i +: 8];
      dout <= mem[mem_addr[g][7:0]];
    end
    if (g == 0) begin : g_b0
      assign bus0 = (!ce_n[0] && !oe_n[0]) ? dout : 'z;
    end else begin : g_b1
      assign bus1 = (!ce_n[1] && !oe_n[1]) ? dout : 'z;
    end
  end

  // Undriven bus reads as Z in 4-state simulators and 0 in 2-state ones.
  function automatic bit floating(input int d);
    logic [DW-1:0] v;
    v = (d != 0) ? bus1 : bus0;
    return (v == '0) || $isunknown(v);
  endfunction

  function automatic logic [DW-1:0] bus_of(input int d);
    return (d != 0) ? bus1 : bus0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one access on DUT d starting at a negedge, follows it sample by
  // sample until ready returns, then checks timing, strobes, bus and data.
  task automatic access(input int d, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [BW-1:0] b,
                        input bit hold, input string tag);
    int acc, rec, n, ack_at, rdy_at, acks, ce_lo, oe_lo, we_lo, pin_bad, drv_bad, flt_bad;
    logic [DW-1:0] exp_rd, cur, rd_at_ack;
    bit [AW:0] key;
    acc = (d != 0) ? 1 : 4;
    rec = (d != 0) ? 3 : 1;
    we[d] = w; addr_in[d] = a; wdata[d] = wd; be[d] = b; req[d] = 1'b1;
    n = 0;
    while (ready[d] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, "/ready_wait"}, ready[d], 1);
    last_acc[d] = cyc + 1;

    key = {d[0], a};
    cur = refm.exists(key) ? refm[key] : '0;
    if (w) begin
      for (int i = 0; i < BW; i++) if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
      refm[key] = cur;
      exp_rd = last_rd[d];
    end else begin
      exp_rd = cur;
      last_rd[d] = cur;
    end

    ack_at = 0; rdy_at = 0; acks = 0; ce_lo = 0; oe_lo = 0; we_lo = 0;
    pin_bad = 0; drv_bad = 0; flt_bad = 0; rd_at_ack = 'x;
    for (int i = 1; i <= 40 && rdy_at == 0; i++) begin
      @(negedge clock);
      if (i == 1 && !hold) begin
        // Inputs wiggled while busy must be ignored.
        req[d] = 1'b0; we[d] = 1'($urandom); addr_in[d] = AW'($urandom);
        wdata[d] = DW'($urandom); be[d] = BW'($urandom);
      end
      if (ack[d] === 1'b1) begin acks++; if (ack_at == 0) ack_at = i; rd_at_ack = rdata[d]; end
      if (ce_n[d] === 1'b0) ce_lo++;
      if (oe_n[d] === 1'b0) oe_lo++;
      if (we_n[d] === 1'b0) we_lo++;
      if ((oe_n[d] === 1'b0 || we_n[d] === 1'b0) && (be_n[d] !== ~b || mem_addr[d] !== a)) pin_bad++;
      if (w && i <= acc + 2) begin
        if (bus_of(d) !== wd) drv_bad++;
      end else if (oe_n[d] === 1'b1 && !floating(d)) flt_bad++;
      if (ready[d] === 1'b1) rdy_at = i;
    end

    chk({tag, "/ack_at"},   ack_at, acc + 2);
    chk({tag, "/acks"},     acks, 1);
    chk({tag, "/ready_at"}, rdy_at, acc + 2 + rec);
    chk({tag, "/ce_lo"},    ce_lo, acc + 1);
    chk({tag, "/we_lo"},    we_lo, w ? acc : 0);
    chk({tag, "/oe_lo"},    oe_lo, w ? 0 : acc);
    chk({tag, "/pins"},     pin_bad, 0);
    chk({tag, "/drive"},    drv_bad, 0);
    chk({tag, "/float"},    flt_bad, 0);
    chk({tag, "/rdata"},    rd_at_ack, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pool [6];
    int t0, t1, t2;
    reset_n = 1'b0; req = '0; we = '0; addr_in = '0; wdata = '0; be = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", ready[d], 1);
      chk("rst_ack",   ack[d], 0);
      chk("rst_rdata", rdata[d], 0);
      chk("rst_ce",    ce_n[d], 1);
      chk("rst_oe",    oe_n[d], 1);
      chk("rst_we",    we_n[d], 1);
      chk("rst_be",    be_n[d], 2'b11);
      chk("rst_addr",  mem_addr[d], 0);
      chk("rst_adv",   adv_n[d], 0);
      chk("rst_float", floating(d), 1);
    end
    @(negedge clock); reset_n = 1'b1; @(negedge clock);

    access(0, 1'b1, 23'h000123, 16'hBEEF, 2'b11, 1'b0, "wr_beef");
    access(0, 1'b0, 23'h000123, 16'h0000, 2'b11, 1'b0, "rd_beef");
    chk("rd_beef_val", rdata[0], 16'hBEEF);
    access(0, 1'b1, 23'h000123, 16'h12AB, 2'b01, 1'b0, "wr_lane");
    access(0, 1'b0, 23'h000123, 16'h0000, 2'b11, 1'b0, "rd_lane");
    chk("rd_lane_val", rdata[0], 16'hBEAB);

    // Reset in the middle of a write's ACCESS phase.
    we[0] = 1'b1; addr_in[0] = 23'h5A5A77; wdata[0] = 16'h3C3C; be[0] = 2'b11; req[0] = 1'b1;
    @(negedge clock); req[0] = 1'b0;
    @(negedge clock);
    chk("abort_pre_we", we_n[0], 0);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_we",    we_n[0], 1);
    chk("abort_ce",    ce_n[0], 1);
    chk("abort_oe",    oe_n[0], 1);
    chk("abort_ack",   ack[0], 0);
    chk("abort_float", floating(0), 1);
    chk("abort_rdata", rdata[0], 0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clock);
    chk("abort_ack2", ack[0], 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_rst_ack",   ack[0], 0);
      chk("post_rst_ready", ready[0], 1);
    end

    // Back-to-back with req held high.
    access(0, 1'b1, 23'h000000, 16'h5A01, 2'b11, 1'b1, "b2b_wr0"); t0 = last_acc[0];
    access(0, 1'b0, 23'h000000, 16'h0000, 2'b11, 1'b1, "b2b_rd0"); t1 = last_acc[0];
    access(0, 1'b1, 23'h7FFFFF, 16'hC3A5, 2'b11, 1'b0, "b2b_wr1"); t2 = last_acc[0];
    chk("b2b_gap1", t1 - t0, 7);
    chk("b2b_gap2", t2 - t1, 7);

    // Randomized traffic over a small pool, including be==0.
    for (int k = 0; k < 6; k++) pool[k] = {15'($urandom_range(0, 32767)), 8'(8'h40 + k)};
    for (int n = 0; n < 16; n++)
      access(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
             DW'($urandom), BW'($urandom), 1'b0, "rnd");
    access(0, 1'b0, pool[0], 16'h0000, 2'b00, 1'b0, "rnd_be0_rd");

    // Short access / long recovery instance.
    access(1, 1'b1, 23'h000055, 16'h9D37, 2'b11, 1'b0, "p1_wr");
    access(1, 1'b1, 23'h000055, 16'h0042, 2'b10, 1'b0, "p1_wr_ub");
    access(1, 1'b0, 23'h000055, 16'h0000, 2'b11, 1'b0, "p1_rd");
    chk("p1_rd_val", rdata[1], 16'h0037);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
